pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Parametrised program-counter unit for the single-cycle RISC-V core. It generalises the sequential/branch PC register to selectable next-PC modes (sequential, PC-relative, register-indirect, return-predicted) and adds a trap redirect and a misaligned-target check. It also contains a circular return-address stack (RAS). It sits between the immediate generator/register file and the instruction-memory address port.

Parameters:
XLEN, 32, PC and operand width in bits
RESET_VECTOR, 0, value loaded into outpc on reset
RAS_DEPTH, 4, number of return-address stack entries (power of two, >=2)

Ports:
clk  input  1  rising-edge clock
asyncreset  input  1  asynchronous active-low reset
load  input  1  advance enable; 0 holds all state
pc_src  input  2  next-PC mode: 00 seq, 01 pc+imm, 10 (rs1+imm)&~1, 11 RAS return
imm  input  XLEN  sign-extended immediate (extout)
rs1  input  XLEN  register operand for indirect jumps
trap_valid  input  1  trap redirect request
trap_vector  input  XLEN  trap target
ras_push  input  1  push pc+4 onto RAS (call)
ras_pop  input  1  pop RAS (return)
outpc  output  XLEN  current PC
pc_plus4  output  XLEN  combinational outpc+4 (link value)
misalign  output  1  registered one-cycle pulse: rejected misaligned target
ras_top  output  XLEN  current top-of-stack entry (combinational)
ras_empty  output  1  RAS count == 0
ras_full  output  1  RAS count == RAS_DEPTH

Behaviour:
- Reset (asyncreset=0, immediate): outpc=RESET_VECTOR, misalign=0, RAS count=0, top pointer=0, entries=0.
- All arithmetic is modulo 2^XLEN. Carries are discarded and the PC wraps silently.
- Target selection: 00 → outpc+4; 01 → outpc+imm; 10 → (rs1+imm) with bit0 cleared; 11 → ras_top if !ras_empty, else outpc+4.
- Priority each clock edge:
  1. trap_valid=1: outpc<=trap_vector with low 2 bits cleared. misalign<=0. RAS unchanged. This applies regardless of load.
  2. Otherwise, load=0: everything holds and misalign<=0.
  3. Otherwise, load=1 and target[1:0]!=0: outpc holds, misalign<=1, RAS ops suppressed.
  4. Otherwise: outpc<=target, misalign<=0, RAS ops applied.
- RAS is circular, with pointer width clog2(RAS_DEPTH):
  - Push: write outpc+4 at ptr+1, ptr<=ptr+1, count<=min(count+1, RAS_DEPTH). When full, the oldest entry is overwritten and ras_full stays 1.
  - Pop: ptr<=ptr-1, count<=count-1. A pop when empty is ignored (no pointer change).
  - Push and pop together: overwrite entry at ptr with outpc+4; ptr and count unchanged. If empty, this acts as a plain push.
  - ras_top = entry[ptr]. It reads the stale/zero entry when empty; consumers must qualify it with ras_empty.
- Latency: outpc updates one cycle after the decision. misalign is valid in the cycle after the rejected attempt.
- Reset mid-operation aborts any pending update, clears the RAS and misalign, and reloads RESET_VECTOR.

Decomposition:
- Shared package (riscv_pkg) holds:
  - PC_SRC_SEQ/PC_SRC_REL/PC_SRC_IND/PC_SRC_RET encodings
  - the instruction byte increment constant (4)
  - the IALIGN mask
- One sub-module, ras_stack, holds the circular RAS (push/pop/top/count/full/empty), parametrised by XLEN and RAS_DEPTH. pc_unit keeps target muxing, priority, and misalign.

Test Plan:
- Reset then load=1, pc_src=00 for 3 cycles → outpc 0,4,8,12; ras_empty=1; misalign=0.
- outpc=0x100, pc_src=01, imm=0xFFFFFFF8 → outpc=0xF8. Then outpc=0xFFFFFFFC with pc_src=00 → outpc=0x0 (wrap).
- outpc=0x40, pc_src=10, rs1=0x1001, imm=0x2 → target 0x1003&~1=0x1002, which is misaligned → outpc stays 0x40 and misalign pulses 1 for one cycle. Then rs1=0x1001, imm=0x3 → outpc=0x1004.
- RAS_DEPTH=4: five pushes from PCs 0x0,0x4,0x8,0xC,0x10 → ras_full=1, ras_top=0x14. Four pops via pc_src=11 → outpc 0x14,0x10,0xC,0x8; ras_empty=1. A fifth pc_src=11 → outpc+4, with no pointer move.
- trap_valid=1, trap_vector=0x203, load=0 → outpc=0x200, RAS unchanged. Simultaneous push+pop at outpc=0x20 → top becomes 0x24, count unchanged.
- asyncreset asserted mid-cycle after two pushes → outpc=RESET_VECTOR immediately, ras_empty=1, misalign=0, with no clock edge needed.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V front end: next-PC mode encodings,
// the sequential instruction increment and the instruction alignment mask.
package riscv_pkg;

   typedef enum logic [1:0] {
      PC_SRC_SEQ = 2'b00,   // outpc + 4
      PC_SRC_REL = 2'b01,   // outpc + imm
      PC_SRC_IND = 2'b10,   // (rs1 + imm) with bit 0 cleared
      PC_SRC_RET = 2'b11    // predicted return from the RAS
   } pc_src_e;

   // Byte distance between consecutive instructions.
   localparam int unsigned INSN_BYTES = 4;

   // Low PC bits that must be zero for a legal fetch target.
   localparam logic [1:0] IALIGN_MASK = 2'b11;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push beyond capacity silently overwrites
// the oldest entry. top always shows entry[ptr], even when the stack is empty.
module ras_stack #(
   parameter int XLEN      = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic            pop,
   input  logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] top,
   output logic            empty,
   output logic            full
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = $clog2(RAS_DEPTH + 1);

   logic [XLEN-1:0] entries_q [RAS_DEPTH];
   logic [XLEN-1:0] entries_d [RAS_DEPTH];
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   wptr;
   logic            do_push, do_pop, do_ovw;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(RAS_DEPTH));
   assign top   = entries_q[ptr_q];
   assign wptr  = ptr_q + PW'(1);

   // Push+pop on a non-empty stack replaces the top in place.
   // On an empty stack the same request behaves as a plain push.
   assign do_push = push && (!pop || empty);
   assign do_pop  = pop && !push && !empty;
   assign do_ovw  = push && pop && !empty;

   // Next-state computation for pointer, occupancy and storage.
   always_comb begin
      entries_d = entries_q;
      ptr_d     = ptr_q;
      count_d   = count_q;
      if (do_push) begin
         entries_d[wptr] = wdata;
         ptr_d           = wptr;
         if (!full) count_d = count_q + CW'(1);
      end else if (do_pop) begin
         ptr_d   = ptr_q - PW'(1);
         count_d = count_q - CW'(1);
      end else if (do_ovw) begin
         entries_d[ptr_q] = wdata;
      end
   end

   // State registers; reset empties the stack and zeroes every entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         count_q <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) entries_q[i] <= '0;
      end else begin
         ptr_q     <= ptr_d;
         count_q   <= count_d;
         entries_q <= entries_d;
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection, trap redirect, misaligned-target
// rejection and a return-address stack for call/return prediction.
module pc_unit
   import riscv_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              RAS_DEPTH    = 4
) (
   input  logic            clk,
   input  logic            asyncreset,
   input  logic            load,
   input  logic [1:0]      pc_src,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_vector,
   input  logic            ras_push,
   input  logic            ras_pop,
   output logic [XLEN-1:0] outpc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            misalign,
   output logic [XLEN-1:0] ras_top,
   output logic            ras_empty,
   output logic            ras_full
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic            misalign_q, misalign_d;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] ind_sum;
   logic            target_bad;
   logic            accept;

   assign outpc    = pc_q;
   assign misalign = misalign_q;
   assign pc_plus4 = pc_q + XLEN'(INSN_BYTES);
   assign ind_sum  = rs1 + imm;

   // Candidate next PC for the selected mode; all sums wrap modulo 2^XLEN.
   always_comb begin
      target = pc_plus4;
      case (pc_src_e'(pc_src))
         PC_SRC_SEQ: target = pc_plus4;
         PC_SRC_REL: target = pc_q + imm;
         PC_SRC_IND: target = {ind_sum[XLEN-1:1], 1'b0};
         PC_SRC_RET: target = ras_empty ? pc_plus4 : ras_top;
         default:    target = pc_plus4;
      endcase
   end

   assign target_bad = |(target[1:0] & IALIGN_MASK);

   // A step is taken only with no trap, load high and an aligned target;
   // RAS updates ride on exactly that condition.
   assign accept = !trap_valid && load && !target_bad;

   // Priority: trap, then hold, then reject misaligned, then advance.
   always_comb begin
      pc_d       = pc_q;
      misalign_d = 1'b0;
      if (trap_valid) begin
         pc_d = trap_vector & ~XLEN'(IALIGN_MASK);
      end else if (!load) begin
         pc_d = pc_q;
      end else if (target_bad) begin
         misalign_d = 1'b1;
      end else begin
         pc_d = target;
      end
   end

   // PC and misalign pulse registers.
   always_ff @(posedge clk or negedge asyncreset) begin
      if (!asyncreset) begin
         pc_q       <= RESET_VECTOR;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
      end
   end

   ras_stack #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk   (clk),
      .rst_n (asyncreset),
      .push  (ras_push && accept),
      .pop   (ras_pop && accept),
      .wdata (pc_plus4),
      .top   (ras_top),
      .empty (ras_empty),
      .full  (ras_full)
   );

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit (XLEN=32, RESET_VECTOR=0, RAS_DEPTH=4).
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        asyncreset;
   logic        load;
   logic [1:0]  pc_src;
   logic [31:0] imm, rs1, trap_vector;
   logic        trap_valid, ras_push, ras_pop;
   logic [31:0] outpc, pc_plus4, ras_top;
   logic        misalign, ras_empty, ras_full;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic        mis;
   } exp_t;

   exp_t sbq[$];

   always #5 clk = ~clk;

   pc_unit #(
      .XLEN         (32),
      .RESET_VECTOR (32'h0),
      .RAS_DEPTH    (4)
   ) dut (
      .clk         (clk),
      .asyncreset  (asyncreset),
      .load        (load),
      .pc_src      (pc_src),
      .imm         (imm),
      .rs1         (rs1),
      .trap_valid  (trap_valid),
      .trap_vector (trap_vector),
      .ras_push    (ras_push),
      .ras_pop     (ras_pop),
      .outpc       (outpc),
      .pc_plus4    (pc_plus4),
      .misalign    (misalign),
      .ras_top     (ras_top),
      .ras_empty   (ras_empty),
      .ras_full    (ras_full)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Drive one cycle of inputs, queue the expected result, clock, then compare.
   task automatic cycle(input string tag, input logic ld, input logic [1:0] src,
                        input logic [31:0] im, input logic [31:0] r1,
                        input logic tv, input logic [31:0] tvec,
                        input logic psh, input logic pp,
                        input logic [31:0] epc, input logic emis);
      exp_t e;
      load        = ld;
      pc_src      = src;
      imm         = im;
      rs1         = r1;
      trap_valid  = tv;
      trap_vector = tvec;
      ras_push    = psh;
      ras_pop     = pp;
      sbq.push_back('{pc: epc, mis: emis});
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      chk({tag, "_pc"}, outpc, e.pc);
      chk({tag, "_mis"}, {31'b0, misalign}, {31'b0, e.mis});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      asyncreset = 1'b0;
      load = 1'b0; pc_src = 2'b00; imm = '0; rs1 = '0;
      trap_valid = 1'b0; trap_vector = '0; ras_push = 1'b0; ras_pop = 1'b0;
      #12;
      chk("rst_pc",    outpc, 32'h0);
      chk("rst_mis",   {31'b0, misalign}, 32'h0);
      chk("rst_empty", {31'b0, ras_empty}, 32'h1);
      chk("rst_full",  {31'b0, ras_full}, 32'h0);
      @(negedge clk);
      asyncreset = 1'b1;

      // Sequential stepping
      cycle("seq1", 1, 2'b00, 0, 0, 0, 0, 0, 0, 32'h4, 0);
      cycle("seq2", 1, 2'b00, 0, 0, 0, 0, 0, 0, 32'h8, 0);
      cycle("seq3", 1, 2'b00, 0, 0, 0, 0, 0, 0, 32'hC, 0);
      chk("seq_empty", {31'b0, ras_empty}, 32'h1);
      chk("seq_plus4", pc_plus4, 32'h10);

      // PC-relative with negative offset, then wrap at the top of the space
      cycle("trap100", 0, 2'b00, 0, 0, 1, 32'h100, 0, 0, 32'h100, 0);
      cycle("rel",     1, 2'b01, 32'hFFFF_FFF8, 0, 0, 0, 0, 0, 32'hF8, 0);
      cycle("trapffc", 0, 2'b00, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 0);
      cycle("wrap",    1, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 0);

      // Indirect: misaligned target rejected, pulse clears, aligned target taken
      cycle("trap40",  0, 2'b00, 0, 0, 1, 32'h40, 0, 0, 32'h40, 0);
      cycle("ind_bad", 1, 2'b10, 32'h2, 32'h1001, 0, 0, 0, 0, 32'h40, 1);
      cycle("hold",    0, 2'b10, 32'h2, 32'h1001, 0, 0, 0, 0, 32'h40, 0);
      cycle("ind_ok",  1, 2'b10, 32'h3, 32'h1001, 0, 0, 0, 0, 32'h1004, 0);

      // RAS overflow then drain
      cycle("trap0", 0, 2'b00, 0, 0, 1, 32'h0, 0, 0, 32'h0, 0);
      chk("pre_push_empty", {31'b0, ras_empty}, 32'h1);
      for (int i = 1; i <= 5; i++)
         cycle($sformatf("push%0d", i), 1, 2'b00, 0, 0, 0, 0, 1, 0, 32'(4 * i), 0);
      chk("ovf_full",  {31'b0, ras_full}, 32'h1);
      chk("ovf_top",   ras_top, 32'h14);
      chk("ovf_empty", {31'b0, ras_empty}, 32'h0);
      cycle("pop1", 1, 2'b11, 0, 0, 0, 0, 0, 1, 32'h14, 0);
      cycle("pop2", 1, 2'b11, 0, 0, 0, 0, 0, 1, 32'h10, 0);
      cycle("pop3", 1, 2'b11, 0, 0, 0, 0, 0, 1, 32'hC, 0);
      cycle("pop4", 1, 2'b11, 0, 0, 0, 0, 0, 1, 32'h8, 0);
      chk("drain_empty", {31'b0, ras_empty}, 32'h1);
      chk("drain_full",  {31'b0, ras_full}, 32'h0);
      cycle("pop5", 1, 2'b11, 0, 0, 0, 0, 0, 1, 32'hC, 0);
      chk("pop5_empty", {31'b0, ras_empty}, 32'h1);
      chk("pop5_top",   ras_top, 32'h14);

      // Trap ignores load and leaves the RAS alone even with a push request
      cycle("trap203", 0, 2'b00, 0, 0, 1, 32'h203, 1, 0, 32'h200, 0);
      chk("trap_empty", {31'b0, ras_empty}, 32'h1);
      chk("trap_top",   ras_top, 32'h14);

      // Push+pop on a one-entry stack replaces the top without changing count
      cycle("trap30", 0, 2'b00, 0, 0, 1, 32'h30, 0, 0, 32'h30, 0);
      cycle("push34", 1, 2'b00, 0, 0, 0, 0, 1, 0, 32'h34, 0);
      chk("push34_top", ras_top, 32'h34);
      cycle("trap20", 0, 2'b00, 0, 0, 1, 32'h20, 0, 0, 32'h20, 0);
      cycle("pushpop", 1, 2'b00, 0, 0, 0, 0, 1, 1, 32'h24, 0);
      chk("pp_top",   ras_top, 32'h24);
      chk("pp_empty", {31'b0, ras_empty}, 32'h0);
      cycle("ret24", 1, 2'b11, 0, 0, 0, 0, 0, 1, 32'h24, 0);
      chk("ret24_empty", {31'b0, ras_empty}, 32'h1);
      cycle("pp_on_empty", 1, 2'b00, 0, 0, 0, 0, 1, 1, 32'h28, 0);
      chk("ppe_top",   ras_top, 32'h28);
      chk("ppe_empty", {31'b0, ras_empty}, 32'h0);

      // Asynchronous reset in the middle of a cycle
      cycle("pushA", 1, 2'b00, 0, 0, 0, 0, 1, 0, 32'h2C, 0);
      cycle("pushB", 1, 2'b00, 0, 0, 0, 0, 1, 0, 32'h30, 0);
      cycle("mis_pre", 1, 2'b10, 32'h2, 32'h1001, 0, 0, 0, 0, 32'h30, 1);
      #2;
      asyncreset = 1'b0;
      #1;
      chk("arst_pc",    outpc, 32'h0);
      chk("arst_mis",   {31'b0, misalign}, 32'h0);
      chk("arst_empty", {31'b0, ras_empty}, 32'h1);
      chk("arst_top",   ras_top, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
